// File: rtl/diamond_pkg.sv
// Shared constants for the diamond collector: box size, the six diamond
// positions, the scan FSM state type and an index-to-position lookup.
package diamond_pkg;

  localparam int DIAM_SIZE = 20;
  localparam int NUM_BLUE  = 3;
  localparam int LAST_IDX  = 5;

  // Blue diamonds are collected by the watergirl.
  localparam logic [9:0] BLUE0_X = 10'd460;
  localparam logic [9:0] BLUE0_Y = 10'd408;
  localparam logic [9:0] BLUE1_X = 10'd366;
  localparam logic [9:0] BLUE1_Y = 10'd238;
  localparam logic [9:0] BLUE2_X = 10'd38;
  localparam logic [9:0] BLUE2_Y = 10'd90;

  // Red diamonds are collected by the fireboy.
  localparam logic [9:0] RED0_X = 10'd330;
  localparam logic [9:0] RED0_Y = 10'd408;
  localparam logic [9:0] RED1_X = 10'd300;
  localparam logic [9:0] RED1_Y = 10'd220;
  localparam logic [9:0] RED2_X = 10'd190;
  localparam logic [9:0] RED2_Y = 10'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Scan index 0..2 are blue diamonds, 3..5 are red diamonds.
  function automatic logic [9:0] diam_x(input logic [2:0] idx);
    case (idx)
      3'd0:    return BLUE0_X;
      3'd1:    return BLUE1_X;
      3'd2:    return BLUE2_X;
      3'd3:    return RED0_X;
      3'd4:    return RED1_X;
      3'd5:    return RED2_X;
      default: return '0;
    endcase
  endfunction

  function automatic logic [9:0] diam_y(input logic [2:0] idx);
    case (idx)
      3'd0:    return BLUE0_Y;
      3'd1:    return BLUE1_Y;
      3'd2:    return BLUE2_Y;
      3'd3:    return RED0_Y;
      3'd4:    return RED1_Y;
      3'd5:    return RED2_Y;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/diamond_overlap.sv
// Combinational strict rectangle intersection test. Sums are taken at
// 11 bits so positions near the 10-bit limit never wrap; rectangles that
// only share an edge do not count as overlapping.
module diamond_overlap (
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [9:0] a_w,
  input  logic [9:0] a_h,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] b_w,
  input  logic [9:0] b_h,
  output logic       hit
);

  logic [10:0] ax, ay, aw, ah, bx, by, bw, bh;

  assign ax = {1'b0, a_x};
  assign ay = {1'b0, a_y};
  assign aw = {1'b0, a_w};
  assign ah = {1'b0, a_h};
  assign bx = {1'b0, b_x};
  assign by = {1'b0, b_y};
  assign bw = {1'b0, b_w};
  assign bh = {1'b0, b_h};

  assign hit = (ax < bx + bw) && (ax + aw > bx) &&
               (ay < by + bh) && (ay + ah > by);

endmodule

// File: rtl/diamond_collector.sv
// Diamond collection tracker. Each rising edge of frame_clk starts a scan
// that checks one diamond per cycle against a snapshot of the character
// positions, records newly collected diamonds and pulses collect_pulse once
// at the end of a scan that found anything new.
module diamond_collector #(
  parameter int CHAR_W = 24,
  parameter int CHAR_H = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       level_restart,
  input  logic [9:0] fire_x,
  input  logic [9:0] fire_y,
  input  logic [9:0] water_x,
  input  logic [9:0] water_y,
  output logic       is_diamond_eat1,
  output logic       is_diamond_eat2,
  output logic       is_diamond_eat3,
  output logic       is_diamond_eat1_red,
  output logic       is_diamond_eat1_red1,
  output logic       is_diamond_eat1_red2,
  output logic [1:0] blue_count,
  output logic [1:0] red_count,
  output logic       all_collected,
  output logic       collect_pulse,
  output logic       scan_busy
);

  import diamond_pkg::*;

  state_t      state, state_d;
  logic        frame_q;
  logic        tick;
  logic [2:0]  idx, idx_d;
  logic [5:0]  flags, flags_d;
  logic [1:0]  blue_cnt, blue_d;
  logic [1:0]  red_cnt, red_d;
  logic        new_hit, new_hit_d;
  logic        all_q, all_d;
  logic        snap_en;
  logic [9:0]  snap_fire_x, snap_fire_y, snap_water_x, snap_water_y;
  logic        is_blue;
  logic [9:0]  char_x, char_y;
  logic        hit;

  assign tick = frame_clk & ~frame_q;

  // Blue slots are tested against the watergirl, red slots against the fireboy.
  assign is_blue = (idx < 3'(NUM_BLUE));
  assign char_x  = is_blue ? snap_water_x : snap_fire_x;
  assign char_y  = is_blue ? snap_water_y : snap_fire_y;

  diamond_overlap u_overlap (
    .a_x (char_x),
    .a_y (char_y),
    .a_w (10'(CHAR_W)),
    .a_h (10'(CHAR_H)),
    .b_x (diam_x(idx)),
    .b_y (diam_y(idx)),
    .b_w (10'(DIAM_SIZE)),
    .b_h (10'(DIAM_SIZE)),
    .hit (hit)
  );

  // Next-state and datapath update for the IDLE/SCAN/DONE scan sequence.
  always_comb begin
    // NOTE: every signal is given a default first so no path can infer a latch.
    state_d       = state;
    idx_d         = idx;
    flags_d       = flags;
    blue_d        = blue_cnt;
    red_d         = red_cnt;
    new_hit_d     = new_hit;
    all_d         = all_q;
    snap_en       = 1'b0;
    collect_pulse = 1'b0;

    if (level_restart) begin
      // Restart wins over any scan activity and any coincident tick.
      state_d   = ST_IDLE;
      idx_d     = '0;
      flags_d   = '0;
      blue_d    = '0;
      red_d     = '0;
      new_hit_d = 1'b0;
      all_d     = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            snap_en = 1'b1;
            idx_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          // An already collected diamond is neither re-flagged nor recounted.
          if (hit && !flags[idx]) begin
            flags_d[idx] = 1'b1;
            new_hit_d    = 1'b1;
            if (is_blue) blue_d = blue_cnt + 2'd1;
            else         red_d  = red_cnt + 2'd1;
          end
          if (idx == 3'(LAST_IDX)) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
        ST_DONE: begin
          collect_pulse = new_hit;
          new_hit_d     = 1'b0;
          all_d         = &flags;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state        <= ST_IDLE;
      frame_q      <= 1'b0;
      idx          <= '0;
      flags        <= '0;
      blue_cnt     <= '0;
      red_cnt      <= '0;
      new_hit      <= 1'b0;
      all_q        <= 1'b0;
      // NOTE: snapshots are reset as well although each scan reloads them,
      // so the whole block has a defined state straight after Reset.
      snap_fire_x  <= '0;
      snap_fire_y  <= '0;
      snap_water_x <= '0;
      snap_water_y <= '0;
    end else begin
      state    <= state_d;
      frame_q  <= frame_clk;
      idx      <= idx_d;
      flags    <= flags_d;
      blue_cnt <= blue_d;
      red_cnt  <= red_d;
      new_hit  <= new_hit_d;
      all_q    <= all_d;
      if (snap_en) begin
        snap_fire_x  <= fire_x;
        snap_fire_y  <= fire_y;
        snap_water_x <= water_x;
        snap_water_y <= water_y;
      end
    end
  end

  assign is_diamond_eat1      = flags[0];
  assign is_diamond_eat2      = flags[1];
  assign is_diamond_eat3      = flags[2];
  assign is_diamond_eat1_red  = flags[3];
  assign is_diamond_eat1_red1 = flags[4];
  assign is_diamond_eat1_red2 = flags[5];
  assign blue_count           = blue_cnt;
  assign red_count            = red_cnt;
  assign all_collected        = all_q;
  assign scan_busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_diamond_collector.sv
// Bench for diamond_collector: directed frames push their expected end-of-scan
// state into a queue; a monitor watches scan_busy and compares when a scan ends.
module tb_diamond_collector;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       level_restart;
  logic [9:0] fire_x, fire_y, water_x, water_y;
  logic       is_diamond_eat1, is_diamond_eat2, is_diamond_eat3;
  logic       is_diamond_eat1_red, is_diamond_eat1_red1, is_diamond_eat1_red2;
  logic [1:0] blue_count, red_count;
  logic       all_collected, collect_pulse, scan_busy;

  typedef struct {
    logic [5:0] flags;
    int         blue;
    int         red;
    int         all_c;
    int         pulses;
    int         len;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  diamond_collector #(.CHAR_W(24), .CHAR_H(32)) dut (
    .Clk                  (Clk),
    .Reset                (Reset),
    .frame_clk            (frame_clk),
    .level_restart        (level_restart),
    .fire_x               (fire_x),
    .fire_y               (fire_y),
    .water_x              (water_x),
    .water_y              (water_y),
    .is_diamond_eat1      (is_diamond_eat1),
    .is_diamond_eat2      (is_diamond_eat2),
    .is_diamond_eat3      (is_diamond_eat3),
    .is_diamond_eat1_red  (is_diamond_eat1_red),
    .is_diamond_eat1_red1 (is_diamond_eat1_red1),
    .is_diamond_eat1_red2 (is_diamond_eat1_red2),
    .blue_count           (blue_count),
    .red_count            (red_count),
    .all_collected        (all_collected),
    .collect_pulse        (collect_pulse),
    .scan_busy            (scan_busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required normal finish");
    $fatal(1, "bench timed out");
  end

  function automatic int flags_now();
    return int'({is_diamond_eat1_red2, is_diamond_eat1_red1, is_diamond_eat1_red,
                 is_diamond_eat3, is_diamond_eat2, is_diamond_eat1});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, flags_now(), 0);
    check({tag, "_blue"}, int'(blue_count), 0);
    check({tag, "_red"}, int'(red_count), 0);
    check({tag, "_all"}, int'(all_collected), 0);
    check({tag, "_pulse"}, int'(collect_pulse), 0);
    check({tag, "_busy"}, int'(scan_busy), 0);
  endtask

  task automatic push(input logic [5:0] f, input int b, input int r,
                      input int a, input int p, input int len);
    exp_t e;
    e.flags  = f;
    e.blue   = b;
    e.red    = r;
    e.all_c  = a;
    e.pulses = p;
    e.len    = len;
    sb_q.push_back(e);
  endtask

  task automatic set_pos(input int wx, input int wy, input int fx, input int fy);
    water_x = 10'(wx);
    water_y = 10'(wy);
    fire_x  = 10'(fx);
    fire_y  = 10'(fy);
  endtask

  // One full frame: frame_clk rises in cycle T (t=0); optional second rise at T+3.
  task automatic run_frame(input int wx, input int wy, input int fx, input int fy,
                           input bit dbl, input bit chk_b0);
    set_pos(wx, wy, fx, fy);
    for (int t = 0; t < 10; t++) begin
      step();
      frame_clk = (t == 0) || (dbl && t == 3);
      @(negedge Clk);
      if (chk_b0 && t == 1) check("b0_flag_T1", int'(is_diamond_eat1), 0);
      if (chk_b0 && t == 2) begin
        check("b0_flag_T2", int'(is_diamond_eat1), 1);
        check("b0_count_T2", int'(blue_count), 1);
      end
      if (t == 7) check("busy_T7", int'(scan_busy), 1);
      if (t >= 8) check("busy_T8_T9", int'(scan_busy), 0);
    end
  endtask

  // Frame cut short at SCAN idx 2 by level_restart (plus a coincident rise) or Reset.
  task automatic abort_frame(input int wx, input int wy, input int fx, input int fy,
                             input bit use_reset);
    set_pos(wx, wy, fx, fy);
    for (int t = 0; t < 6; t++) begin
      step();
      frame_clk     = (t == 0) || (!use_reset && (t == 3 || t == 4));
      level_restart = !use_reset && (t == 3);
      Reset         = use_reset && (t == 3);
      @(negedge Clk);
      if (t == 3) check("abort_busy_idx2", int'(scan_busy), 1);
      if (use_reset && t == 3) check("b1_flag_pre_reset", int'(is_diamond_eat2), 1);
      if (t == 4) check_zero(use_reset ? "midscan_reset" : "restart_scan");
      if (t == 5) check("abort_no_rescan", int'(scan_busy), 0);
    end
  endtask

  task automatic do_restart();
    step();
    level_restart = 1'b1;
    step();
    level_restart = 1'b0;
    @(negedge Clk);
    check_zero("restart_idle");
  endtask

  // Monitor: measures each busy period and compares the state when it ends.
  initial begin
    bit   busy_prev;
    int   len, pulses, off;
    exp_t e;
    busy_prev = 1'b0;
    len       = 0;
    pulses    = 0;
    off       = -1;
    forever begin
      @(negedge Clk);
      if (scan_busy) begin
        if (!busy_prev) begin
          len    = 0;
          pulses = 0;
          off    = -1;
        end
        if (collect_pulse) begin
          pulses++;
          off = len;
        end
        len++;
      end else if (busy_prev) begin
        check("sb_has_entry", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("sb_flags", flags_now(), int'(e.flags));
          check("sb_blue_count", int'(blue_count), e.blue);
          check("sb_red_count", int'(red_count), e.red);
          check("sb_all_collected", int'(all_collected), e.all_c);
          check("sb_pulse_count", pulses, e.pulses);
          if (e.pulses > 0) check("sb_pulse_at_T7", off, 6);
          check("sb_busy_len", len, e.len);
        end
      end
      busy_prev = scan_busy;
    end
  end

  initial begin
    Reset         = 1'b1;
    frame_clk     = 1'b0;
    level_restart = 1'b0;
    set_pos(600, 0, 0, 300);
    repeat (3) step();
    Reset = 1'b0;
    step();
    @(negedge Clk);
    check_zero("reset");

    // Fireboy over a blue diamond's area: nothing collected.
    push(6'b000000, 0, 0, 0, 0, 7);
    run_frame(600, 0, 450, 400, 1'b0, 1'b0);

    // Watergirl overlaps blue 0: flag at T+2, pulse at T+7.
    push(6'b000001, 1, 0, 0, 1, 7);
    run_frame(450, 400, 0, 300, 1'b0, 1'b1);

    // Watergirl on red 0, fireboy on blue 0: wrong colours, no change.
    push(6'b000001, 1, 0, 0, 0, 7);
    run_frame(330, 408, 460, 408, 1'b0, 1'b0);

    // Second frame_clk rise at T+3 is ignored; busy falls at T+8.
    push(6'b000001, 1, 0, 0, 0, 7);
    run_frame(600, 0, 0, 300, 1'b1, 1'b0);

    // level_restart at SCAN idx 2 with coincident tick, then a normal frame.
    push(6'b000000, 0, 0, 0, 0, 3);
    abort_frame(460, 408, 0, 300, 1'b0);
    push(6'b000001, 1, 0, 0, 1, 7);
    run_frame(460, 408, 0, 300, 1'b0, 1'b1);

    // Reset mid-scan after blue 1 was flagged: nothing retained.
    push(6'b000000, 0, 0, 0, 0, 3);
    abort_frame(366, 238, 0, 300, 1'b1);

    // Edge touching (436+24=460) is no overlap; one pixel further is.
    push(6'b000000, 0, 0, 0, 0, 7);
    run_frame(436, 400, 0, 300, 1'b0, 1'b0);
    push(6'b000001, 1, 0, 0, 1, 7);
    run_frame(437, 400, 0, 300, 1'b0, 1'b1);

    do_restart();

    // Visit all six diamonds over six frames, then a frame with nothing new.
    push(6'b000001, 1, 0, 0, 1, 7);
    run_frame(460, 408, 0, 300, 1'b0, 1'b0);
    push(6'b000011, 2, 0, 0, 1, 7);
    run_frame(366, 238, 0, 300, 1'b0, 1'b0);
    push(6'b000111, 3, 0, 0, 1, 7);
    run_frame(38, 90, 0, 300, 1'b0, 1'b0);
    push(6'b001111, 3, 1, 0, 1, 7);
    run_frame(600, 0, 330, 408, 1'b0, 1'b0);
    push(6'b011111, 3, 2, 0, 1, 7);
    run_frame(600, 0, 300, 220, 1'b0, 1'b0);
    push(6'b111111, 3, 3, 1, 1, 7);
    run_frame(600, 0, 190, 42, 1'b0, 1'b0);
    push(6'b111111, 3, 3, 1, 0, 7);
    run_frame(460, 408, 330, 408, 1'b0, 1'b0);

    repeat (3) step();
    @(negedge Clk);
    check("sb_drained", int'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
